// File: rtl/mem_stage_arb.sv
// MEM pipeline stage: XM->MW register plus a single-port data memory shared by core and host.
// Define MEM_SUBWORD_EN for byte/half-word core accesses (requires DW = 32).
module mem_stage_arb #(
  parameter int unsigned DW       = 32,
  parameter int unsigned DEPTH    = 256,
  parameter int unsigned MAX_WAIT = 4,
  localparam int unsigned AW      = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          XM_MemtoReg,
  input  logic          XM_RegWrite,
  input  logic          XM_MemRead,
  input  logic          XM_MemWrite,
  input  logic [1:0]    XM_Size,
  input  logic          XM_Unsigned,
  input  logic [DW-1:0] ALUout,
  input  logic [DW-1:0] XM_MD,
  input  logic [4:0]    XM_RD,
  input  logic          bsy,
  input  logic          hreq,
  input  logic          hwe,
  input  logic [AW-1:0] haddr,
  input  logic [DW-1:0] hdin,
  output logic          hack,
  output logic [DW-1:0] hdout,
  output logic          mem_stall,
  output logic          MW_MemtoReg,
  output logic          MW_RegWrite,
  output logic [DW-1:0] MW_ALUout,
  output logic [4:0]    MW_RD,
  output logic [DW-1:0] MDR
);

  localparam int unsigned CW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam logic [CW-1:0] WaitLast = (MAX_WAIT > 0) ? CW'(MAX_WAIT - 1) : '0;

  typedef enum logic [1:0] {StIdle, StWait, StHost, StAck} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic          mw_memtoreg_q, mw_memtoreg_d;
  logic          mw_regwrite_q, mw_regwrite_d;
  logic [DW-1:0] mw_aluout_q, mw_aluout_d;
  logic [4:0]    mw_rd_q, mw_rd_d;
  logic [DW-1:0] rword_q, rword_d;
  logic [DW-1:0] hdout_q, hdout_d;

  logic          core_mem, host_act, core_rd, core_wr;
  logic [AW-1:0] core_idx, mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic [DW-1:0] mem [DEPTH];

  assign core_mem  = bsy & (XM_MemRead | XM_MemWrite);
  assign host_act  = (state_q == StHost);
  assign mem_stall = host_act & core_mem;
  assign core_rd   = bsy & XM_MemRead & ~host_act;
  // Read wins when both strobes are high.
  assign core_wr   = bsy & XM_MemWrite & ~XM_MemRead & ~host_act;
  assign core_idx  = ALUout[AW+1:2];
  assign hack      = (state_q == StAck);
  assign hdout     = hdout_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (hreq) begin
          if (!core_mem || MAX_WAIT == 0) begin
            state_d = StHost;
          end else begin
            state_d = StWait;
            cnt_d   = '0;
          end
        end
      end
      StWait: begin
        if (!core_mem || cnt_q == WaitLast) begin
          state_d = StHost;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StHost:  state_d = StAck;
      StAck:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    mem_addr  = host_act ? haddr : core_idx;
    mem_we    = host_act ? hwe : core_wr;
    mem_wdata = host_act ? hdin : XM_MD;
  end

  assign mem_rdata = mem[mem_addr];

`ifdef MEM_SUBWORD_EN
  logic [1:0] off_q, off_d;
  logic [1:0] size_q, size_d;
  logic       uns_q, uns_d;
  logic [3:0] mem_be;
  logic [31:0] lane_wdata;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Stores replicate the datum into every lane; byte enables pick the target lanes.
  always_comb begin
    mem_be     = 4'hF;
    lane_wdata = mem_wdata;
    if (!host_act) begin
      unique case (XM_Size)
        2'b00: begin
          mem_be     = 4'b0001 << ALUout[1:0];
          lane_wdata = {4{XM_MD[7:0]}};
        end
        2'b01: begin
          mem_be     = ALUout[1] ? 4'b1100 : 4'b0011;
          lane_wdata = {2{XM_MD[15:0]}};
        end
        default: begin
          mem_be     = 4'hF;
          lane_wdata = XM_MD;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (mem_we && mem_be[i]) begin
        mem[mem_addr][8*i +: 8] <= lane_wdata[8*i +: 8];
      end
    end
  end

  always_comb begin
    off_d  = core_rd ? ALUout[1:0] : off_q;
    size_d = core_rd ? XM_Size : size_q;
    uns_d  = core_rd ? XM_Unsigned : uns_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      off_q  <= '0;
      size_q <= '0;
      uns_q  <= 1'b0;
    end else begin
      off_q  <= off_d;
      size_q <= size_d;
      uns_q  <= uns_d;
    end
  end

  // Lane select and extension happen after the register so MDR lines up with MW_*.
  always_comb begin
    byte_sel = rword_q[{off_q, 3'b000} +: 8];
    half_sel = off_q[1] ? rword_q[31:16] : rword_q[15:0];
    unique case (size_q)
      2'b00:   MDR = {{24{~uns_q & byte_sel[7]}}, byte_sel};
      2'b01:   MDR = {{16{~uns_q & half_sel[15]}}, half_sel};
      default: MDR = rword_q;
    endcase
  end

  logic unused_addr_hi;
  assign unused_addr_hi = ^ALUout[DW-1:AW+2];
`else
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
  end

  assign MDR = rword_q;

  logic unused_subword;
  assign unused_subword = ^{XM_Size, XM_Unsigned, ALUout[1:0], ALUout[DW-1:AW+2]};
`endif

  always_comb begin
    // A stalled access turns the MW slot into a bubble; address/RD still flow.
    mw_memtoreg_d = XM_MemtoReg & ~mem_stall;
    mw_regwrite_d = XM_RegWrite & ~mem_stall;
    mw_aluout_d   = ALUout;
    mw_rd_d       = XM_RD;
    rword_d       = core_rd ? mem_rdata : rword_q;
    hdout_d       = (host_act && !hwe) ? mem_rdata : hdout_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      mw_memtoreg_q <= 1'b0;
      mw_regwrite_q <= 1'b0;
      mw_aluout_q   <= '0;
      mw_rd_q       <= '0;
      rword_q       <= '0;
      hdout_q       <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      mw_memtoreg_q <= mw_memtoreg_d;
      mw_regwrite_q <= mw_regwrite_d;
      mw_aluout_q   <= mw_aluout_d;
      mw_rd_q       <= mw_rd_d;
      rword_q       <= rword_d;
      hdout_q       <= hdout_d;
    end
  end

  assign MW_MemtoReg = mw_memtoreg_q;
  assign MW_RegWrite = mw_regwrite_q;
  assign MW_ALUout   = mw_aluout_q;
  assign MW_RD       = mw_rd_q;

endmodule
